// File: rtl/climber_jump_pkg.sv
// Shared definitions for the climber jump physics block and the platform scroller.
package climber_jump_pkg;

  localparam int unsigned Y_W    = 10;
  localparam int unsigned EXT_W  = 11;
  localparam int unsigned TICK_W = 20;
  localparam int unsigned APEX_W = 4;

  localparam logic [EXT_W-1:0]  SCREEN_ROWS      = 11'd480;
  localparam logic [TICK_W-1:0] DEFAULT_TICK_DIV = 20'd840000;

  typedef enum logic [2:0] {
    GROUND,
    RISE,
    APEX,
    FALL,
    DEAD
  } state_e;

  // Row that puts the sprite's feet on the platform top, clamped at the screen top.
  function automatic logic [Y_W-1:0] ground_row(input logic [Y_W-1:0] top,
                                                input logic [Y_W-1:0] height);
    logic [EXT_W-1:0] diff;
    diff = EXT_W'(top) - EXT_W'(height);
    return diff[EXT_W-1] ? '0 : diff[Y_W-1:0];
  endfunction

endpackage

// File: rtl/climber_jump_tick_gen.sv
// Physics tick generator: one-cycle strobe every TICK_DIV+1 clocks.
module climber_jump_tick_gen
  import climber_jump_pkg::*;
#(
  parameter logic [TICK_W-1:0] TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_c
);

  logic [TICK_W-1:0] count;

  assign tick_c = (count == TICK_DIV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tick_c) begin
      count <= '0;
    end else begin
      count <= count + TICK_W'(1);
    end
  end

endmodule

// File: rtl/climber_jump.sv
// Climber vertical motion: jump button capture and ground/rise/apex/fall/dead FSM
// advanced once per physics tick.
module climber_jump
  import climber_jump_pkg::*;
#(
  parameter logic [TICK_W-1:0] TICK_DIV    = DEFAULT_TICK_DIV,
  parameter logic [Y_W-1:0]    PLAYER_H    = 10'd32,
  parameter logic [Y_W-1:0]    JUMP_HEIGHT = 10'd64,
  parameter logic [Y_W-1:0]    STEP        = 10'd2,
  parameter logic [APEX_W-1:0] APEX_TICKS  = 4'd8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           jump_btn,
  input  logic [Y_W-1:0] plataform_start,
  input  logic [Y_W-1:0] plataform_end,
  output logic [Y_W-1:0] player_y,
  output logic           on_ground,
  output logic           dead
);

  state_e            state;
  logic              tick_c;
  logic              btn_meta, btn_sync, btn_prev;
  logic              jump_pending;
  logic [Y_W-1:0]    base_y;
  logic [APEX_W-1:0] apex_cnt;

  logic              jump_rise_c, jump_req_c, gone_c, apex_reached_c, landing_c;
  logic [Y_W-1:0]    land_y_c, rise_y_c;
  logic [EXT_W-1:0]  feet_c, feet_next_c;

  climber_jump_tick_gen #(.TICK_DIV(TICK_DIV)) tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_c (tick_c)
  );

  // Two-flop synchronizer plus a history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      btn_meta <= jump_btn;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
    end
  end

  assign jump_rise_c    = btn_sync & ~btn_prev;
  assign jump_req_c     = jump_pending | jump_rise_c;
  assign land_y_c       = ground_row(plataform_start, PLAYER_H);
  assign gone_c         = EXT_W'(plataform_start) >= (SCREEN_ROWS + EXT_W'(PLAYER_H));
  assign rise_y_c       = player_y - STEP;
  assign apex_reached_c = (base_y - rise_y_c) >= JUMP_HEIGHT;
  assign feet_c         = EXT_W'(player_y) + EXT_W'(PLAYER_H);
  assign feet_next_c    = feet_c + EXT_W'(STEP);
  assign landing_c      = (feet_next_c >= EXT_W'(plataform_start)) &&
                          (feet_c <= EXT_W'(plataform_end));

  // Motion FSM; everything but jump capture moves only on the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= GROUND;
      player_y     <= '0;
      on_ground    <= 1'b1;
      dead         <= 1'b0;
      base_y       <= '0;
      apex_cnt     <= '0;
      jump_pending <= 1'b0;
    end else if (tick_c) begin
      jump_pending <= 1'b0;
      case (state)
        GROUND: begin
          if (gone_c) begin
            state     <= DEAD;
            on_ground <= 1'b0;
            dead      <= 1'b1;
          end else begin
            player_y <= land_y_c;
            if (jump_req_c) begin
              base_y    <= land_y_c;
              state     <= RISE;
              on_ground <= 1'b0;
            end
          end
        end
        RISE: begin
          if (player_y < STEP) begin
            player_y <= '0;
            apex_cnt <= '0;
            state    <= APEX;
          end else begin
            player_y <= rise_y_c;
            if (apex_reached_c) begin
              apex_cnt <= '0;
              state    <= APEX;
            end
          end
        end
        APEX: begin
          if (apex_cnt == (APEX_TICKS - APEX_W'(1))) begin
            apex_cnt <= '0;
            state    <= FALL;
          end else begin
            apex_cnt <= apex_cnt + APEX_W'(1);
          end
        end
        FALL: begin
          if (landing_c) begin
            player_y  <= land_y_c;
            state     <= GROUND;
            on_ground <= 1'b1;
          end else if (feet_next_c >= SCREEN_ROWS) begin
            state <= DEAD;
            dead  <= 1'b1;
          end else begin
            player_y <= player_y + STEP;
          end
        end
        default: begin
        end
      endcase
    end else if (jump_rise_c && (state == GROUND)) begin
      jump_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_climber_jump.sv
// Directed bench for climber_jump: per-tick expectations queued and checked after each tick.
module tb_climber_jump;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       jump_btn = 1'b0;
  logic [9:0] plataform_start = 10'd100;
  logic [9:0] plataform_end = 10'd110;
  logic [9:0] player_y;
  logic       on_ground;
  logic       dead;

  typedef struct {
    int y;
    bit g;
    bit d;
    bit chk_y;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   fails = 0;
  int   cyc;

  climber_jump #(.TICK_DIV(20'd3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .jump_btn        (jump_btn),
    .plataform_start (plataform_start),
    .plataform_end   (plataform_end),
    .player_y        (player_y),
    .on_ground       (on_ground),
    .dead            (dead)
  );

  always #5 clk = ~clk;

  // Bench-side tick phase: with TICK_DIV=3 the DUT updates on every 4th edge after release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_tick(input string tag);
    exp_t e;
    do begin
      @(posedge clk);
      #1;
    end while ((cyc % 4) != 0);
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      if (e.chk_y) check({tag, ".y"}, player_y, 10'(e.y));
      check({tag, ".on_ground"}, 10'(on_ground), 10'(e.g));
      check({tag, ".dead"}, 10'(dead), 10'(e.d));
    end
  endtask

  task automatic expect_tick(input string tag, input int y, input bit g, input bit d,
                             input bit chk_y = 1'b1);
    exp_t e;
    e.y = y; e.g = g; e.d = d; e.chk_y = chk_y;
    sb.push_back(e);
    step_tick(tag);
  endtask

  task automatic rise_and_apex(input string tag, input int first_i);
    for (int i = first_i; i <= 32; i++) expect_tick(tag, 68 - 2 * i, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) expect_tick({tag, ".apex"}, 4, 1'b0, 1'b0);
  endtask

  task automatic fall_and_land(input string tag, input int from_y);
    for (int y = from_y + 2; y <= 66; y += 2) expect_tick(tag, y, 1'b0, 1'b0);
    expect_tick({tag, ".land"}, 68, 1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".y"}, player_y, 10'd0);
    check({tag, ".on_ground"}, 10'(on_ground), 10'd1);
    check({tag, ".dead"}, 10'(dead), 10'd0);
  endtask

  initial begin
    #12;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    // Ground tracking and tick-only sampling of the platform
    expect_tick("ground100", 68, 1'b1, 1'b0);
    plataform_start = 10'd101; plataform_end = 10'd111;
    expect_tick("ground101", 69, 1'b1, 1'b0);
    plataform_start = 10'd300;
    @(posedge clk);
    #1;
    plataform_start = 10'd100; plataform_end = 10'd110;
    expect_tick("between_ticks", 68, 1'b1, 1'b0);

    // Full jump from row 68
    jump_btn = 1'b1;
    expect_tick("takeoff", 68, 1'b0, 1'b0);
    jump_btn = 1'b0;
    rise_and_apex("rise", 1);
    fall_and_land("fall", 4);
    expect_tick("rest", 68, 1'b1, 1'b0);

    // Platform near the top: ground clamps to 0 and the rise hits apex at once
    plataform_start = 10'd20; plataform_end = 10'd30;
    expect_tick("clamp_ground", 0, 1'b1, 1'b0);
    jump_btn = 1'b1;
    expect_tick("clamp_takeoff", 0, 1'b0, 1'b0);
    jump_btn = 1'b0;
    expect_tick("clamp_rise", 0, 1'b0, 1'b0);
    plataform_start = 10'd100; plataform_end = 10'd110;
    for (int i = 0; i < 8; i++) expect_tick("clamp_apex", 0, 1'b0, 1'b0);
    fall_and_land("clamp_fall", 0);

    // Edge arriving in the tick cycle itself, then an ignored press during the rise
    @(posedge clk);
    #1;
    jump_btn = 1'b1;
    expect_tick("coincident", 68, 1'b0, 1'b0);
    jump_btn = 1'b0;
    expect_tick("co_rise1", 66, 1'b0, 1'b0);
    jump_btn = 1'b1;
    expect_tick("co_rise2", 64, 1'b0, 1'b0);
    jump_btn = 1'b0;
    rise_and_apex("co_rise", 3);
    fall_and_land("co_fall", 4);
    expect_tick("no_rejump1", 68, 1'b1, 1'b0);
    expect_tick("no_rejump2", 68, 1'b1, 1'b0);

    // Platform yanked off screen mid-fall: fall to the bottom and die
    jump_btn = 1'b1;
    expect_tick("d_takeoff", 68, 1'b0, 1'b0);
    jump_btn = 1'b0;
    rise_and_apex("d_rise", 1);
    expect_tick("d_fall1", 6, 1'b0, 1'b0);
    plataform_start = 10'd600; plataform_end = 10'd610;
    for (int y = 8; y <= 446; y += 2) expect_tick("d_fall", y, 1'b0, 1'b0);
    expect_tick("dead", 446, 1'b0, 1'b1);
    jump_btn = 1'b1;
    expect_tick("dead_jump", 446, 1'b0, 1'b1);
    jump_btn = 1'b0;
    expect_tick("dead_hold", 446, 1'b0, 1'b1);

    // Asynchronous reset out of DEAD
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_dead");
    plataform_start = 10'd100; plataform_end = 10'd110;
    @(negedge clk) rst_n = 1'b1;
    expect_tick("post_reset", 68, 1'b1, 1'b0);
    jump_btn = 1'b1;
    expect_tick("r_takeoff", 68, 1'b0, 1'b0);
    jump_btn = 1'b0;
    expect_tick("r_rise1", 66, 1'b0, 1'b0);
    expect_tick("r_rise2", 64, 1'b0, 1'b0);

    // Asynchronous reset mid-rise, between clock edges
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_rise");
    plataform_start = 10'd511; plataform_end = 10'd520;
    @(negedge clk) rst_n = 1'b1;

    // Off-screen boundary: 511 still on screen, 512 kills
    expect_tick("edge511", 479, 1'b1, 1'b0);
    plataform_start = 10'd512;
    expect_tick("offscreen", 0, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/climber_jump.md
CLIMBER_JUMP -- requirements
Module: climber_jump

Interface
REQ-001 Parameter TICK_DIV, default 20'd840000, means clock cycles between physics ticks; it matches the platform scroll step.
REQ-002 Parameter PLAYER_H, default 10'd32, means climber sprite height in rows.
REQ-003 Parameter JUMP_HEIGHT, default 10'd64, means maximum rise in rows above the take-off row.
REQ-004 Parameter STEP, default 10'd2, means rows moved per tick while rising or falling.
REQ-005 Parameter APEX_TICKS, default 4'd8, means ticks held at the apex.
REQ-006 Port clk, input, 1 bit, is the single system clock; all flops use its rising edge.
REQ-007 Port rst_n, input, 1 bit, is the asynchronous active-low reset.
REQ-008 Port jump_btn, input, 1 bit, is the raw asynchronous jump button, active-high.
REQ-009 Port plataform_start, input, 10 bits, is the platform top screen row from the upstream scroller.
REQ-010 Port plataform_end, input, 10 bits, is the platform bottom row, equal to plataform_start + height.
REQ-011 Port player_y, output, 10 bits, registered, is the climber sprite top row.
REQ-012 Port on_ground, output, 1 bit, registered, is high in GROUND state.
REQ-013 Port dead, output, 1 bit, registered, is high in DEAD state.

Function
REQ-014 jump_btn SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized signal SHALL set jump_pending.
REQ-015 A 20-bit tick counter SHALL count 0..TICK_DIV; tick SHALL be high for the one cycle at which count == TICK_DIV, and count SHALL return to 0 on the next cycle.
REQ-016 All state and player_y updates SHALL occur only on tick cycles; jump_pending SHALL clear on every tick cycle.
REQ-017 FSM states: GROUND, RISE, APEX, FALL, DEAD.
REQ-018 GROUND behaviour:
- player_y = plataform_start − PLAYER_H, computed at 11-bit width and clamped to 0 if negative.
- If jump_pending is set on the tick, capture base_y = player_y and go to RISE.
REQ-019 RISE behaviour:
- player_y −= STEP each tick.
- Go to APEX when base_y − player_y ≥ JUMP_HEIGHT, or when player_y < STEP; the latter clamps player_y to 0.
REQ-020 APEX SHALL hold player_y for APEX_TICKS ticks, then go to FALL.
REQ-021 FALL behaviour, with feet = player_y + PLAYER_H at 11 bits:
- If feet + STEP ≥ plataform_start and feet ≤ plataform_end, snap player_y = plataform_start − PLAYER_H and go to GROUND.
- Else if feet + STEP ≥ 480, go to DEAD.
- Otherwise player_y += STEP.
REQ-022 DEAD SHALL freeze player_y, hold dead = 1, and ignore jump until reset.
REQ-023 Platform inputs SHALL be sampled only on the tick cycle; changes between ticks have no effect.
REQ-024 In GROUND, if plataform_start ≥ 480 + PLAYER_H (the platform has scrolled off screen), the FSM SHALL go to DEAD.
REQ-025 A jump edge arriving on the same cycle as tick SHALL be honoured on that tick.
REQ-026 Jump edges arriving in RISE, APEX, FALL or DEAD SHALL be discarded, with no buffering.

Reset
REQ-027 While rst_n = 0, all of the following SHALL hold immediately, independent of clk:
- state = GROUND, player_y = 0, on_ground = 1, dead = 0.
- tick counter = 0, apex counter = 0, base_y = 0, jump_pending = 0, synchronizer flops = 0.
REQ-028 Reset asserted mid-jump or in DEAD SHALL return the block to the REQ-027 state; the first update SHALL be on the first tick after release.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, SCREEN_ROWS = 480, and the default TICK_DIV shared with the platform scroller.
REQ-030 The sub-module tick_gen SHALL contain the tick counter; the synchronizer and FSM SHALL stay in climber_jump.

Verification
REQ-031 All scenarios SHALL use TICK_DIV = 3 for simulation.
REQ-032 Reset, then plataform_start = 100, no jump -> after 1 tick player_y = 68 and on_ground = 1; after plataform_start = 101, next tick player_y = 69.
REQ-033 GROUND, player_y = 68, one jump pulse -> RISE; player_y steps 66, 64, ... 4 over 32 ticks, then APEX for 8 ticks, then falls by 2 per tick and lands at plataform_start − 32 with on_ground = 1.
REQ-034 Start plataform_start = 20, then jump -> player_y clamps to 0 when it would go negative, and the FSM goes to APEX early.
REQ-035 During FALL, plataform_start is forced to 600 -> player descends until feet + 2 ≥ 480, then dead = 1 and player_y is frozen; jump pulses are ignored.
REQ-036 Jump pulse coincident with tick -> RISE on that tick; a second pulse during RISE produces no re-jump after landing.
REQ-037 rst_n pulled low mid-RISE between clock edges -> outputs read 0/1/0 before the next clk edge.
